// File: rtl/instruction_fetch_pkg.sv
// Shared opcode constants and IF/ID payload types for the fetch stage.
package instruction_fetch_pkg;

  localparam int unsigned XLEN = 32;

  // RV32 SYSTEM major opcode; ECALL is the all-zero-field SYSTEM instruction.
  localparam logic [6:0]      OPCODE_SYSTEM = 7'b111_0011;
  localparam logic [XLEN-1:0] ECALL_INST    = {25'd0, OPCODE_SYSTEM};

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } if_state_e;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } if_id_t;

  // Fetch targets are always word aligned.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_pc_register.sv
// Program counter register with async active-low reset and load enable.
module pc_register
  import instruction_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_load,
  input  logic [XLEN-1:0] i_next_pc,
  output logic [XLEN-1:0] o_pc
);

  logic [XLEN-1:0] r_pc;

  // Load the next PC when enabled, otherwise hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_next_pc;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC sequencing, IF/ID register, redirect and ECALL halt.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] HALT_INST = ECALL_INST
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_dout,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_inst,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc_plus4,
  output logic            halted,
  output logic [XLEN-1:0] fetch_count
);

  if_state_e       r_state;
  if_state_e       w_state_next;
  if_id_t          r_if_id;
  if_id_t          w_if_id_next;
  logic            r_valid;
  logic            w_valid_next;
  logic [XLEN-1:0] r_count;
  logic [XLEN-1:0] w_count_next;
  logic [XLEN-1:0] w_pc;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_pc_next;
  logic            w_pc_load;
  logic            w_accept;

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_pc_load),
    .i_next_pc (w_pc_next),
    .o_pc      (w_pc)
  );

  assign w_pc_plus4 = w_pc + XLEN'(4);
  assign w_accept   = (r_state == FETCH) && !redirect_valid && (!r_valid || id_ready);

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, next PC and next IF/ID contents; redirect outranks everything.
  always_comb begin
    w_state_next = r_state;
    w_pc_load    = 1'b0;
    w_pc_next    = w_pc;
    w_if_id_next = r_if_id;
    w_valid_next = r_valid;
    w_count_next = r_count;
    if (redirect_valid) begin
      w_state_next = FETCH;
      w_pc_load    = 1'b1;
      w_pc_next    = align_pc(redirect_pc);
      w_valid_next = 1'b0;
    end else if (w_accept) begin
      w_if_id_next = '{inst: imem_dout, pc: w_pc, pc_plus4: w_pc_plus4};
      w_valid_next = 1'b1;
      w_count_next = r_count + XLEN'(1);
      w_pc_load    = 1'b1;
      if (imem_dout == HALT_INST) begin
        // Park on the halting instruction so imem_addr keeps pointing at it.
        w_state_next = HALT;
        w_pc_next    = w_pc;
      end else begin
        w_pc_next    = w_pc_plus4;
      end
    end else if (r_valid && id_ready) begin
      w_valid_next = 1'b0;
    end
  end

  // IF/ID pipeline register and fetch counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_if_id <= '0;
      r_valid <= 1'b0;
      r_count <= '0;
    end else begin
      r_if_id <= w_if_id_next;
      r_valid <= w_valid_next;
      r_count <= w_count_next;
    end
  end

  assign imem_addr      = w_pc;
  assign if_id_valid    = r_valid;
  assign if_id_inst     = r_if_id.inst;
  assign if_id_pc       = r_if_id.pc;
  assign if_id_pc_plus4 = r_if_id.pc_plus4;
  assign halted         = (r_state == HALT);
  assign fetch_count    = r_count;

endmodule
